alu_seq_exec: RTL and testbench

Sequential execution unit that consumes the 4-bit `ALU_sel` code produced by the ALU control unit and carries out the selected operation on two operands. Logic/arithmetic ops complete in one cycle. Shifts run iteratively, one bit position per cycle, with a start/ready/valid handshake toward the datapath controller. It sits in the EX stage of the multi-cycle RISC-V datapath, downstream of `ALUControlUnit`.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_comb_core.sv | 33 +++
 rtl/alu_seq_exec.sv | 111 +++++++++++
 tb/tb_alu_seq_exec.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage sequential ALU: operation codes,
// FSM state encoding and a helper that classifies the shift operations.
package alu_pkg;

    // Operation codes produced by ALUControlUnit
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    // Execution FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // True for the codes that run through the iterative shifter
    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle combinational part of the ALU. Shift codes pass operand A
// through unchanged, which is exactly the result of a shift by zero; real
// shifts are handled by the iterative shifter in the parent.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [3:0]   i_sel,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_result,
    output logic         o_illegal
);

    // Decode the operation code and compute the one-cycle result
    always_comb begin
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_sel)
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_ADD:  o_result = i_a + i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLT:  o_result = {{(N-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(N-1){1'b0}}, (i_a < i_b)};
            ALU_SLL, ALU_SRL, ALU_SRA: o_result = i_a;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential execution unit for the multi-cycle RISC-V EX stage. Logic and
// arithmetic ops finish in one cycle; shifts move one bit per cycle. The
// unit accepts a new request in the DONE cycle, so single-cycle ops can
// stream at one per clock.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   ALU_sel,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         valid,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         illegal
);

    logic [1:0]     r_state;
    logic [SHW-1:0] r_cnt;
    logic [N-1:0]   r_work;
    logic [3:0]     r_op;
    logic [N-1:0]   r_result;
    logic           r_zero;
    logic           r_illegal;

    logic           w_accept;
    logic [SHW-1:0] w_shamt;
    logic           w_goShift;
    logic [N-1:0]   w_coreResult;
    logic           w_coreIllegal;
    logic [N-1:0]   w_shiftNext;

    alu_comb_core #(.N(N)) u_core (
        .i_sel     (ALU_sel),
        .i_a       (a),
        .i_b       (b),
        .o_result  (w_coreResult),
        .o_illegal (w_coreIllegal)
    );

    assign ready     = (r_state != ST_SHIFT);
    assign valid     = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;
    assign w_accept  = start && ready;
    assign w_shamt   = b[SHW-1:0];
    assign w_goShift = is_shift(ALU_sel) && (w_shamt != '0);

    // One-bit shift of the working register in the direction of the latched op
    always_comb begin
        w_shiftNext = r_work;
        case (r_op)
            ALU_SLL: w_shiftNext = {r_work[N-2:0], 1'b0};
            ALU_SRL: w_shiftNext = {1'b0, r_work[N-1:1]};
            ALU_SRA: w_shiftNext = {r_work[N-1], r_work[N-1:1]};
            default: w_shiftNext = r_work;
        endcase
    end

    // Control FSM, shift counter, working register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_op      <= ALU_AND;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (w_goShift) begin
                            r_state <= ST_SHIFT;
                            r_work  <= a;
                            r_cnt   <= w_shamt;
                            r_op    <= ALU_sel;
                        end else begin
                            r_state   <= ST_DONE;
                            r_result  <= w_coreResult;
                            r_zero    <= (w_coreResult == '0);
                            r_illegal <= w_coreIllegal;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_shiftNext;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == SHW'(1)) begin
                        r_state   <= ST_DONE;
                        r_result  <= w_shiftNext;
                        r_zero    <= (w_shiftNext == '0);
                        r_illegal <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: directed requests push their expected
// result and completion cycle; a monitor pops and compares on every valid.
module tb_alu_seq_exec;
    import alu_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   aluSel = 4'b0000;
    logic [N-1:0] opA = '0;
    logic [N-1:0] opB = '0;
    logic         ready;
    logic         valid;
    logic [N-1:0] result;
    logic         zero;
    logic         illegal;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [N-1:0] res;
        logic         zer;
        logic         ill;
        int           cyc;
    } expT;

    expT sbQ[$];

    alu_seq_exec #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ALU_sel (aluSel),
        .a       (opA),
        .b       (opB),
        .ready   (ready),
        .valid   (valid),
        .result  (result),
        .zero    (zero),
        .illegal (illegal)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to check completion latency
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison with failure reporting
    task automatic checkOutput(input string name, input logic [N-1:0] actual,
                               input logic [N-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Issue one request once the unit is ready; optionally record its expectation
    task automatic applyStimulus(input logic [3:0] sel, input logic [N-1:0] av,
                                 input logic [N-1:0] bv, input logic [N-1:0] expRes,
                                 input logic expIll, input int lat, input bit track);
        int waited;
        waited = 0;
        @(negedge clk);
        while (ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: ready=%b after %0d cycles", ready, waited);
        end
        aluSel = sel;
        opA    = av;
        opB    = bv;
        start  = 1'b1;
        if (track)
            sbQ.push_back('{res: expRes, zer: (expRes == '0), ill: expIll, cyc: cyc + 1 + lat});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        expT e;
        if (valid === 1'b1) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got result %h with nothing outstanding", result);
            end else begin
                e = sbQ.pop_front();
                checkOutput("result", result, e.res);
                checkOutput("zero", N'(zero), N'(e.zer));
                checkOutput("illegal", N'(illegal), N'(e.ill));
                checkOutput("valid_cycle", N'(cyc), N'(e.cyc));
                checkOutput("ready_in_done", N'(ready), N'(1));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int w;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", N'(ready), N'(1));
        checkOutput("reset_valid", N'(valid), N'(0));
        checkOutput("reset_result", result, N'(0));
        checkOutput("reset_zero", N'(zero), N'(0));
        checkOutput("reset_illegal", N'(illegal), N'(0));
        rst_n = 1'b1;

        applyStimulus(ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 0, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("hold_result", result, 32'd12);
        checkOutput("idle_ready", N'(ready), N'(1));

        applyStimulus(ALU_SUB,  32'd9, 32'd9, 32'd0, 1'b0, 0, 1'b1);
        applyStimulus(ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0, 1'b1);
        applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 1'b1);

        applyStimulus(ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("sra_ready_low", N'(ready), N'(0));
        end

        applyStimulus(ALU_SLL, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 0, 1'b1);

        applyStimulus(ALU_SLL, 32'd1, 32'd3, 32'd8, 1'b0, 3, 1'b1);
        @(negedge clk);
        aluSel = ALU_ADD;
        opA    = 32'd100;
        opB    = 32'd1;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        applyStimulus(ALU_SLL, 32'd3, 32'd10, 32'd0, 1'b0, 10, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_ready", N'(ready), N'(1));
        checkOutput("abort_valid", N'(valid), N'(0));
        checkOutput("abort_result", result, N'(0));
        checkOutput("abort_zero", N'(zero), N'(0));
        checkOutput("abort_illegal", N'(illegal), N'(0));

        applyStimulus(ALU_ADD, 32'h10, 32'h20, 32'h30, 1'b0, 0, 1'b1);
        applyStimulus(4'b0011, 32'd5, 32'd6, 32'd0, 1'b1, 0, 1'b1);

        applyStimulus(ALU_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 0, 1'b1);
        applyStimulus(ALU_OR,  32'h0F0F, 32'hF000, 32'hFF0F, 1'b0, 0, 1'b1);
        applyStimulus(ALU_XOR, 32'hAA,   32'hFF,   32'h55,   1'b0, 0, 1'b1);

        applyStimulus(ALU_SRL, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 31, 1'b1);
        applyStimulus(ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 0, 1'b1);

        w = 0;
        while (sbQ.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drain", N'(sbQ.size()), N'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
